shreg_seq: RTL and testbench
============================

SHREG_SEQ -- requirements
Module: shreg_seq

Interface
REQ-001 Parameter SHIFT_LEN, default 8: number of shift cycles per frame, legal range 1..15.
REQ-002 Parameter GAP, default 0: number of hold cycles after each frame, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  byte offered on in_data/in_dir/fill.
REQ-006 in_ready  output  1  sequencer can accept a byte.
REQ-007 in_data  input  8  byte to load into the downstream s74194.
REQ-008 in_dir  input  1  0 = shift right (mode 01), 1 = shift left (mode 10).
REQ-009 fill  input  1  serial fill bit presented on sin during shifting.
REQ-010 mode  output  2  s74194 mode: 00 hold, 01 shift right, 10 shift left, 11 load.
REQ-011 pin  output  8  s74194 parallel input.
REQ-012 sin  output  1  s74194 serial input.
REQ-013 busy  output  1  a frame is in progress (any state except IDLE).
REQ-014 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT, PAR, GAP; PAR exists only when SHREG_SEQ_PARITY_EN is defined.
REQ-016 in_ready SHALL be 1 only in IDLE and not during reset; a transfer occurs on the rising edge where in_valid && in_ready.
REQ-017 On transfer, the block SHALL latch in_data, in_dir and fill, and SHALL enter LOAD.
REQ-018 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-019 LOAD lasts exactly 1 cycle, with mode=11 and pin=latched byte.
REQ-020 SHIFT lasts exactly SHIFT_LEN cycles, with mode=01 or 10 per the latched in_dir and sin=latched fill; a 4-bit down-counter times it.
REQ-021 pin SHALL hold the latched byte from LOAD through the end of the frame.
REQ-022 In IDLE and GAP, the block SHALL drive mode=00 and sin=0.
REQ-023 After SHIFT (or PAR), the FSM SHALL enter GAP for GAP cycles, or enter IDLE directly when GAP=0.
REQ-024 done SHALL be 1 for exactly one cycle: the first cycle after the final SHIFT/PAR cycle.
REQ-025 Frame period from transfer edge to next possible transfer SHALL be 1 + SHIFT_LEN (+1 if parity) + GAP + 1 cycles.
REQ-026 in_valid or input changes during a frame SHALL NOT affect the frame; a held in_valid is accepted exactly once, on return to IDLE.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set state=IDLE, mode=00, pin=8'h00, sin=0, busy=0, done=0 and in_ready=0; in_ready=1 from the following cycle.
REQ-028 Reset mid-frame SHALL abort the frame with no done pulse; rst has priority over every transition.

Configuration
REQ-029 Macro SHREG_SEQ_PARITY_EN defined: after SHIFT, one PAR cycle SHALL drive mode=latched direction code and sin=^latched byte (even parity).
REQ-030 Macro SHREG_SEQ_PARITY_EN undefined: no PAR state, and SHIFT goes directly to GAP/IDLE.

Structure
REQ-031 Shared package shreg_pkg SHALL hold the mode constants MODE_HOLD/MODE_SHR/MODE_SHL/MODE_LOAD and the state encoding; s74194 benches reuse them.
REQ-032 No sub-module is needed inside shreg_seq; the bench SHALL instantiate s74194 downstream, with mode/pin/sin wired directly.

Verification
REQ-033 Reset: rst high 2 cycles mid-idle -> mode=00, pin=00, sin=0, busy=0, done=0; in_ready=1 one cycle after release.
REQ-034 Byte 8'h1A, dir=0, fill=1 -> 1 cycle mode=11 pin=1A, 8 cycles mode=01 sin=1, done pulse; s74194 pout=8'hFF.
REQ-035 Byte 8'h3C, dir=1, fill=0 -> 8 cycles mode=10, done pulse; s74194 pout=8'h00; busy high for 9 cycles.
REQ-036 in_valid held high with 8'h2B queued during a frame -> in_ready=0 until IDLE; 2B accepted exactly once; GAP=2 gives 2 hold cycles before in_ready.
REQ-037 rst asserted in the 4th SHIFT cycle -> next cycle mode=00, busy=0, no done; the next byte frames normally.
REQ-038 With SHREG_SEQ_PARITY_EN: byte 8'h01 -> 9th shift cycle sin=1; byte 8'h35 -> 9th shift cycle sin=0.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared constants for the s74194 frame sequencer: mode codes and FSM state encoding.
// SHREG_SEQ_PARITY_EN adds the PAR state.
package shreg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef SHREG_SEQ_PARITY_EN
        ST_PAR   = 3'd4,
`endif
        ST_GAP   = 3'd3
    } state_t;

    function automatic logic [1:0] dir_mode(input logic dir);
        return dir ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/shreg_seq_if.sv
// Byte-offer handshake into the sequencer.
interface shreg_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic       fill;

    modport master (output in_valid, in_data, in_dir, fill, input in_ready);
    modport slave  (input in_valid, in_data, in_dir, fill, output in_ready);
endinterface

// File: rtl/s74194.sv
// 8-bit universal shift register in the style of a 74194; the sequencer's downstream load.
module s74194
    import shreg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [7:0] pin,
    input  logic       sin,
    output logic [7:0] pout
);
    always_ff @(posedge clk) begin
        if (rst) begin
            pout <= 8'h00;
        end else begin
            case (mode)
                MODE_SHR:  pout <= {sin, pout[7:1]};
                MODE_SHL:  pout <= {pout[6:0], sin};
                MODE_LOAD: pout <= pin;
                default:   pout <= pout;
            endcase
        end
    end
endmodule

// File: rtl/shreg_seq.sv
// Frame sequencer driving an s74194: LOAD, SHIFT_LEN shifts, optional parity, GAP holds.
// Define SHREG_SEQ_PARITY_EN to append one even-parity shift cycle per frame.
module shreg_seq
    import shreg_pkg::*;
#(
    parameter int SHIFT_LEN = 8,
    parameter int GAP       = 0
) (
    input  logic        clk,
    input  logic        rst,
    shreg_seq_if.slave  bus,
    output logic [1:0]  mode,
    output logic [7:0]  pin,
    output logic        sin,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] LEN_M1 = 4'(SHIFT_LEN - 1);
    localparam logic [3:0] GAP_M1 = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       dir_q, fill_q, ready_q;
    logic [1:0] mode_n;
    logic       sin_n, done_n, take;

    assign take         = bus.in_valid && ready_q;
    assign bus.in_ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            mode    <= MODE_HOLD;
            pin     <= 8'h00;
            sin     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready_q <= 1'b0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mode    <= mode_n;
            sin     <= sin_n;
            busy    <= (state_n != ST_IDLE);
            done    <= done_n;
            ready_q <= (state_n == ST_IDLE);
            // pin doubles as the latched byte for the whole frame
            if (take) begin
                pin    <= bus.in_data;
                dir_q  <= bus.in_dir;
                fill_q <= bus.fill;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: if (take) state_n = ST_LOAD;
            ST_LOAD: begin
                state_n = ST_SHIFT;
                cnt_n   = LEN_M1;
            end
            ST_SHIFT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
`ifdef SHREG_SEQ_PARITY_EN
                    state_n = ST_PAR;
`else
                    done_n  = 1'b1;
                    state_n = (GAP == 0) ? ST_IDLE : ST_GAP;
                    cnt_n   = GAP_M1;
`endif
                end
            end
`ifdef SHREG_SEQ_PARITY_EN
            ST_PAR: begin
                done_n  = 1'b1;
                state_n = (GAP == 0) ? ST_IDLE : ST_GAP;
                cnt_n   = GAP_M1;
            end
`endif
            ST_GAP: begin
                if (cnt != 4'd0) cnt_n = cnt - 4'd1;
                else             state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // outputs are registered, so decode them from the upcoming state
        mode_n = MODE_HOLD;
        sin_n  = 1'b0;
        case (state_n)
            ST_LOAD:  mode_n = MODE_LOAD;
            ST_SHIFT: begin
                mode_n = dir_mode(dir_q);
                sin_n  = fill_q;
            end
`ifdef SHREG_SEQ_PARITY_EN
            ST_PAR: begin
                mode_n = dir_mode(dir_q);
                sin_n  = ^pin;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_shreg_seq.sv
// Directed bench for shreg_seq: GAP=0 instance feeding an s74194, plus a GAP=2 instance.
// Honors SHREG_SEQ_PARITY_EN for frame length and the parity vectors.
module tb_shreg_seq;
    import shreg_pkg::*;

    localparam int SL = 8;
`ifdef SHREG_SEQ_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       dir   = 1'b0;
    logic       fill  = 1'b0;

    shreg_seq_if bus0 ();
    shreg_seq_if bus2 ();
    assign bus0.in_valid = valid;
    assign bus0.in_data  = data;
    assign bus0.in_dir   = dir;
    assign bus0.fill     = fill;
    assign bus2.in_valid = valid;
    assign bus2.in_data  = data;
    assign bus2.in_dir   = dir;
    assign bus2.fill     = fill;

    logic [1:0] mode0, mode2;
    logic [7:0] pin0, pin2, pout0;
    logic       sin0, sin2, busy0, busy2, done0, done2;

    shreg_seq #(.SHIFT_LEN(SL), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .mode(mode0), .pin(pin0),
        .sin(sin0), .busy(busy0), .done(done0));
    shreg_seq #(.SHIFT_LEN(SL), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .mode(mode2), .pin(pin2),
        .sin(sin2), .busy(busy2), .done(done2));
    s74194 u_sr0 (
        .clk(clk), .rst(rst), .mode(mode0), .pin(pin0), .sin(sin0), .pout(pout0));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // one full frame on dut0 (GAP=0), checked cycle by cycle
    task automatic run_frame(input logic [7:0] d, input logic dr, input logic f,
                             input logic [7:0] exp_pout);
        int bc;
        data = d; dir = dr; fill = f; valid = 1'b1;
        step;
        valid = 1'b0;
        chk("load_mode", 32'(mode0), 32'(MODE_LOAD));
        chk("load_pin", 32'(pin0), 32'(d));
        chk("load_rdy", 32'(bus0.in_ready), 32'd0);
        bc = busy0 ? 1 : 0;
        for (int i = 0; i < SL; i++) begin
            step;
            chk("shf_mode", 32'(mode0), 32'(dr ? MODE_SHL : MODE_SHR));
            chk("shf_sin", 32'(sin0), 32'(f));
            chk("shf_pin", 32'(pin0), 32'(d));
            chk("shf_done", 32'(done0), 32'd0);
            if (busy0) bc++;
        end
`ifdef SHREG_SEQ_PARITY_EN
        step;
        chk("par_mode", 32'(mode0), 32'(dr ? MODE_SHL : MODE_SHR));
        chk("par_sin", 32'(sin0), 32'(^d));
        if (busy0) bc++;
`endif
        step;
        chk("end_done", 32'(done0), 32'd1);
        chk("end_busy", 32'(busy0), 32'd0);
        chk("end_mode", 32'(mode0), 32'(MODE_HOLD));
        chk("end_sin", 32'(sin0), 32'd0);
        chk("end_rdy", 32'(bus0.in_ready), 32'd1);
        chk("end_pout", 32'(pout0), 32'(exp_pout));
        chk("busy_len", 32'(bc), 32'(1 + SL + PB));
        step;
        chk("done_once", 32'(done0), 32'd0);
    endtask

    initial begin
        int k, n, nd;
        logic got;

        // reset from power-up
        rst = 1'b1;
        step; step;
        chk("rst_mode", 32'(mode0), 32'(MODE_HOLD));
        chk("rst_pin", 32'(pin0), 32'h00);
        chk("rst_sin", 32'(sin0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_rdy", 32'(bus0.in_ready), 32'd0);
        rst = 1'b0;
        step;
        chk("rel_rdy", 32'(bus0.in_ready), 32'd1);

        run_frame(8'h1A, 1'b0, 1'b1, 8'hFF);
        run_frame(8'h3C, 1'b1, 1'b0, 8'h00);

        // reset in idle clears the retained byte
        rst = 1'b1;
        step; step;
        chk("idle_rst_pin", 32'(pin0), 32'h00);
        chk("idle_rst_rdy", 32'(bus0.in_ready), 32'd0);
        chk("idle_rst_pout", 32'(pout0), 32'h00);
        rst = 1'b0;
        step;
        chk("idle_rel_rdy", 32'(bus0.in_ready), 32'd1);
        chk("idle_rel_rdy2", 32'(bus2.in_ready), 32'd1);

        // held in_valid with a queued byte, GAP=2 instance
        data = 8'h5A; dir = 1'b0; fill = 1'b0; valid = 1'b1;
        step;
        data = 8'h2B;
        chk("q_load_pin", 32'(pin2), 32'h5A);
        k = 1; got = 1'b0;
        while (k < 40 && !got) begin
            step;
            k++;
            if (bus2.in_ready) got = 1'b1;
            else if (k == SL + PB + 2) chk("q_gap_done", 32'(done2), 32'd1);
            else if (k == SL + PB + 3) begin
                chk("q_gap_mode", 32'(mode2), 32'(MODE_HOLD));
                chk("q_gap_busy", 32'(busy2), 32'd1);
            end
        end
        chk("q_wait", 32'(k), 32'(1 + SL + PB + 2 + 1));
        step;
        valid = 1'b0;
        chk("q2_mode", 32'(mode2), 32'(MODE_LOAD));
        chk("q2_pin", 32'(pin2), 32'h2B);
        n = 0; nd = 0;
        repeat (30) begin
            step;
            if (mode2 == MODE_LOAD) n++;
            if (done2) nd++;
        end
        chk("q2_once", 32'(n), 32'd0);
        chk("q2_done", 32'(nd), 32'd1);

        // reset during the 4th shift cycle
        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
        data = 8'h77; dir = 1'b0; fill = 1'b0; valid = 1'b1;
        step;
        valid = 1'b0;
        repeat (4) step;
        chk("mid_shift", 32'(mode0), 32'(MODE_SHR));
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_mode", 32'(mode0), 32'(MODE_HOLD));
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        step;
        chk("abort_done2", 32'(done0), 32'd0);
        chk("abort_rdy", 32'(bus0.in_ready), 32'd1);
        run_frame(8'hC3, 1'b1, 1'b1, (PB == 1) ? 8'hFE : 8'hFF);

`ifdef SHREG_SEQ_PARITY_EN
        run_frame(8'h01, 1'b0, 1'b0, 8'h80);
        run_frame(8'h35, 1'b0, 1'b0, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
